fu_wb_queue: RTL

//   Per-FU writeback holding queue between one functional unit and the CDB arbiter.
//   - Accepts completed FU_PACKETs from its FU.
//   - Presents the oldest held packet to the CDB as one fu_done/wr_data lane.
//   - Retains that packet until the CDB grants it (stall bit low).
//   - Lets the FU keep issuing while it loses CDB arbitration; back-pressures only when full.

---
 rtl/fu_wb_queue_if.sv | 26 ++
 rtl/fu_wb_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/fu_wb_queue_if.sv
// FU-to-CDB writeback lane bundle: FU result handshake in, CDB fu_done/wr_data/stall out.
// The queue takes the slave view; the FU/CDB side takes the master view.
interface fu_wb_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter type fu_packet_t = logic [63:0]
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            in_valid;
    fu_packet_t      in_packet;
    logic            in_ready;
    logic            out_valid;
    fu_packet_t      out_packet;
    logic            cdb_stall;
    logic [CW-1:0]   count;

    modport slave (
        input  in_valid, in_packet, cdb_stall,
        output in_ready, out_valid, out_packet, count
    );

    modport master (
        output in_valid, in_packet, cdb_stall,
        input  in_ready, out_valid, out_packet, count
    );
endinterface

// File: rtl/fu_wb_queue.sv
// Per-FU writeback holding queue: FIFO of completed FU packets waiting for a CDB grant.
// Optional same-cycle bypass when empty is enabled by defining FU_WB_BYPASS_EN.
module fu_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter type fu_packet_t = logic [63:0]
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    fu_wb_queue_if.slave  wb
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    fu_packet_t      mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            empty;
    logic            in_ready;
    logic            out_valid;
    logic            bypass;
    logic            push;
    logic            pop;

    // Explicit wrap so non-power-of-2 depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q < CW'(DEPTH));
        bypass   = 1'b0;
`ifdef FU_WB_BYPASS_EN
        bypass   = empty && wb.in_valid && !squash;
`endif
        out_valid = !empty || bypass;

        if (!empty) begin
            wb.out_packet = mem_q[head_q];
        end else if (bypass) begin
            wb.out_packet = wb.in_packet;
        end else begin
            wb.out_packet = '0;
        end

        push = wb.in_valid && in_ready;
        pop  = out_valid && !wb.cdb_stall;
        // A bypassed packet never touches the pointers; it is stored only if not granted.
        if (bypass) begin
            push = wb.cdb_stall;
            pop  = 1'b0;
        end

        wb.in_ready  = in_ready;
        wb.out_valid = out_valid;
        wb.count     = count_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; only head/count decide what is visible.
    always_ff @(posedge clock) begin
        if (!reset && !squash && push) begin
            mem_q[tail_q] <= wb.in_packet;
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        count_q <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge clock) disable iff (reset)
        !(wb.in_valid && !in_ready));
    a_valid_has_entry: assert property (@(posedge clock) disable iff (reset)
        out_valid |-> (count_q != '0) || bypass);
`endif
endmodule
